// File: rtl/ipsxe_floating_point_pkg.sv
// ipsxe_floating_point_pkg: shared widths, tag type and clog2 for the multiplier arbiter
package ipsxe_floating_point_pkg;

    localparam int ID_MAX_W = 3;

    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
    } tag_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int w_of(input int exp_width, input int man_width);
        return 1 + exp_width + man_width;
    endfunction

    function automatic int pw_of(input int exp_width, input int man_width);
        return 2 * (man_width + 1) + (exp_width + 1) + 1;
    endfunction

endpackage

// File: rtl/ipsxe_floating_point_mul_arbiter_v1_0_if.sv
// ipsxe_floating_point_mul_arbiter_v1_0_if: requester, multiplier and result bus of the arbiter
interface ipsxe_floating_point_mul_arbiter_v1_0_if
    import ipsxe_floating_point_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int EXP_WIDTH   = 8,
    parameter int MAN_WIDTH   = 23,
    parameter int MUL_LATENCY = 3
) ();
    localparam int W   = w_of(EXP_WIDTH, MAN_WIDTH);
    localparam int PW  = pw_of(EXP_WIDTH, MAN_WIDTH);
    localparam int IDW = clog2(N_REQ);
    localparam int CW  = clog2(MUL_LATENCY + 2);

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ*W-1:0]  req_a;
    logic [N_REQ*W-1:0]  req_b;
    logic [W-1:0]        mul_a;
    logic [W-1:0]        mul_b;
    logic                mul_issue;
    logic [PW-1:0]       mul_p;
    logic [N_REQ-1:0]    res_valid;
    logic [PW-1:0]       res_data;
    logic [IDW-1:0]      res_id;
    logic [N_REQ*CW-1:0] inflight;
    logic                idle;

    modport slave (
        input  req_valid, req_a, req_b, mul_p,
        output req_ready, mul_a, mul_b, mul_issue, res_valid, res_data, res_id, inflight, idle
    );

    modport master (
        output req_valid, req_a, req_b, mul_p,
        input  req_ready, mul_a, mul_b, mul_issue, res_valid, res_data, res_id, inflight, idle
    );

endinterface

// File: rtl/ipsxe_floating_point_register_v1_0.sv
// ipsxe_floating_point_register_v1_0: enabled register with asynchronous active-low clear
module ipsxe_floating_point_register_v1_0 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    // load on enable, otherwise hold
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= '0;
        else if (en) q <= d;

endmodule

// File: rtl/ipsxe_floating_point_rr_grant_v1_0.sv
// ipsxe_floating_point_rr_grant_v1_0: one-hot round-robin pick starting at ptr
module ipsxe_floating_point_rr_grant_v1_0
    import ipsxe_floating_point_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IDW  = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDW-1:0]   id
);
    logic [2*N_REQ-1:0] rot_dbl;
    logic [2*N_REQ-1:0] gnt_dbl;
    logic [N_REQ-1:0]   rot;
    logic [N_REQ-1:0]   pick;

    // rotate so ptr is bit 0, isolate lowest set bit, rotate back, encode index
    always_comb begin
        rot_dbl = {req, req} >> ptr;
        rot     = rot_dbl[N_REQ-1:0];
        pick    = rot & (~rot + N_REQ'(1));
        gnt_dbl = {pick, pick} << ptr;
        gnt     = gnt_dbl[2*N_REQ-1:N_REQ];
        id      = '0;
        for (int i = 0; i < N_REQ; i++)
            if (gnt[i]) id = IDW'(i);
    end

endmodule

// File: rtl/ipsxe_floating_point_mul_arbiter_v1_0.sv
// ipsxe_floating_point_mul_arbiter_v1_0: round-robin sharing of one pipelined multiplier with tagged returns
module ipsxe_floating_point_mul_arbiter_v1_0
    import ipsxe_floating_point_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int EXP_WIDTH   = 8,
    parameter int MAN_WIDTH   = 23,
    parameter int MUL_LATENCY = 3
) (
    input logic i_clk,
    input logic i_rst_n,
    input logic i_aclken,
    ipsxe_floating_point_mul_arbiter_v1_0_if.slave bus
);
    localparam int W     = w_of(EXP_WIDTH, MAN_WIDTH);
    localparam int PW    = pw_of(EXP_WIDTH, MAN_WIDTH);
    localparam int IDW   = clog2(N_REQ);
    localparam int CW    = clog2(MUL_LATENCY + 2);
    localparam int DEPTH = MUL_LATENCY + 1;
    localparam int TW    = $bits(tag_t);

    logic [N_REQ-1:0]    gnt;
    logic [IDW-1:0]      gnt_id;
    logic [IDW-1:0]      ptr;
    logic [IDW-1:0]      ptr_next;
    logic                accept;
    logic                ret;
    logic [IDW-1:0]      ret_id;
    logic [N_REQ-1:0]    res_onehot;
    logic [N_REQ-1:0]    res_valid_q;
    logic [PW+IDW-1:0]   res_q;
    logic [2*W-1:0]      opnd_q;
    logic                issue_q;
    logic [N_REQ*CW-1:0] cnt;
    logic [N_REQ*CW-1:0] cnt_next;
    tag_t                tag_in;
    tag_t                tag [DEPTH];

    ipsxe_floating_point_rr_grant_v1_0 #(.N_REQ(N_REQ)) u_grant (
        .req (bus.req_valid),
        .ptr (ptr),
        .gnt (gnt),
        .id  (gnt_id)
    );

    // accept, pointer advance, issue tag, return decode and outstanding-count update
    always_comb begin
        accept     = i_aclken && (|gnt);
        ptr_next   = (gnt_id == IDW'(N_REQ - 1)) ? '0 : gnt_id + IDW'(1);
        tag_in     = '0;
        tag_in.valid = accept;
        tag_in.id  = ID_MAX_W'(gnt_id);
        ret        = tag[DEPTH-1].valid;
        ret_id     = IDW'(tag[DEPTH-1].id);
        res_onehot = ret ? N_REQ'(1) << ret_id : '0;
        cnt_next   = cnt;
        for (int k = 0; k < N_REQ; k++)
            cnt_next[k*CW +: CW] = cnt[k*CW +: CW] + CW'(accept && gnt_id == IDW'(k)) - CW'(ret && ret_id == IDW'(k));
    end

    // drive the bus from registered state; ready is the grant gated by the clock enable
    always_comb begin
        bus.req_ready = i_aclken ? gnt : '0;
        bus.mul_a     = opnd_q[2*W-1:W];
        bus.mul_b     = opnd_q[W-1:0];
        bus.mul_issue = issue_q;
        bus.res_valid = res_valid_q;
        bus.res_data  = res_q[IDW +: PW];
        bus.res_id    = res_q[IDW-1:0];
        bus.inflight  = cnt;
        bus.idle      = (cnt == '0) && !accept;
    end

    ipsxe_floating_point_register_v1_0 #(.WIDTH(IDW)) u_ptr (
        .clk(i_clk), .rst_n(i_rst_n), .en(accept), .d(ptr_next), .q(ptr)
    );

    ipsxe_floating_point_register_v1_0 #(.WIDTH(2*W)) u_opnd (
        .clk(i_clk), .rst_n(i_rst_n), .en(accept),
        .d({bus.req_a[gnt_id*W +: W], bus.req_b[gnt_id*W +: W]}), .q(opnd_q)
    );

    ipsxe_floating_point_register_v1_0 #(.WIDTH(1)) u_issue (
        .clk(i_clk), .rst_n(i_rst_n), .en(i_aclken), .d(accept), .q(issue_q)
    );

    // entry 0 sits alongside the operand registers; the last entry lines up with the product
    for (genvar g = 0; g < DEPTH; g++) begin : g_tag
        ipsxe_floating_point_register_v1_0 #(.WIDTH(TW)) u_tag (
            .clk(i_clk), .rst_n(i_rst_n), .en(i_aclken),
            .d(g == 0 ? tag_in : tag[g == 0 ? 0 : g-1]), .q(tag[g])
        );
    end

    ipsxe_floating_point_register_v1_0 #(.WIDTH(PW+IDW)) u_res (
        .clk(i_clk), .rst_n(i_rst_n), .en(i_aclken && ret), .d({bus.mul_p, ret_id}), .q(res_q)
    );

    ipsxe_floating_point_register_v1_0 #(.WIDTH(N_REQ)) u_res_valid (
        .clk(i_clk), .rst_n(i_rst_n), .en(i_aclken), .d(res_onehot), .q(res_valid_q)
    );

    ipsxe_floating_point_register_v1_0 #(.WIDTH(N_REQ*CW)) u_cnt (
        .clk(i_clk), .rst_n(i_rst_n), .en(i_aclken), .d(cnt_next), .q(cnt)
    );

endmodule
